neuron_operand_loader: RTL and testbench



---
 rtl/neuron_operand_loader_pkg.sv | 25 ++
 rtl/neuron_operand_loader_bank.sv | 66 ++++++
 rtl/neuron_operand_loader.sv | 143 ++++++++++++++
 tb/tb_neuron_operand_loader.sv | 118 +++++++++++
 4 files changed

// File: rtl/neuron_operand_loader_pkg.sv
// Shared definitions for the neuron operand loader slice.
//   DATA_W_DEFAULT : default operand word width
//   N_WORDS        : operand words per neuron (3 x/w pairs), fixed
//   CNT_W          : width of a bank fill count (0..N_WORDS)
//   load_state_t   : loader FSM states
//   SEL_*          : pair-select codes driven by neuron_control
package dnn_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int N_WORDS        = 6;
    localparam int CNT_W          = 3;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FULL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } load_state_t;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_P1   = 2'd1;
    localparam logic [1:0] SEL_P2   = 2'd2;
    localparam logic [1:0] SEL_P3   = 2'd3;

endpackage

// File: rtl/neuron_operand_loader_bank.sv
// operand_bank: six operand registers with indexed write, synchronous clear
// and a sel-driven x/w pair read mux.
// Optional feature macro: OPLOAD_DOUBLE_BUF_EN adds a whole-bank parallel
// load (copy_en/copy_data) and a flat view of the contents (words).
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   clr             : synchronous clear of all words
//   we/waddr/wdata  : single-word write
//   sel             : pair select (0 = none, 1..3 = pair 1..3)
//   op_x/op_w       : selected pair, zero when sel = 0
module operand_bank
    import dnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      we,
    input  logic [CNT_W-1:0]          waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [1:0]                sel,
`ifdef OPLOAD_DOUBLE_BUF_EN
    input  logic                      copy_en,
    input  logic [N_WORDS*DATA_W-1:0] copy_data,
    output logic [N_WORDS*DATA_W-1:0] words,
`endif
    output logic [DATA_W-1:0]         op_x,
    output logic [DATA_W-1:0]         op_w
);

    logic [DATA_W-1:0] mem [N_WORDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_WORDS; i++) mem[i] <= '0;
`ifdef OPLOAD_DOUBLE_BUF_EN
        end else if (copy_en) begin
            for (int i = 0; i < N_WORDS; i++) mem[i] <= copy_data[i*DATA_W +: DATA_W];
`endif
        end else if (clr) begin
            for (int i = 0; i < N_WORDS; i++) mem[i] <= '0;
        end else if (we && (waddr < CNT_W'(N_WORDS))) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef OPLOAD_DOUBLE_BUF_EN
    always_comb begin
        words = '0;
        for (int i = 0; i < N_WORDS; i++) words[i*DATA_W +: DATA_W] = mem[i];
    end
`endif

    always_comb begin
        op_x = '0;
        op_w = '0;
        case (sel)
            SEL_P1:  begin op_x = mem[0]; op_w = mem[1]; end
            SEL_P2:  begin op_x = mem[2]; op_w = mem[3]; end
            SEL_P3:  begin op_x = mem[4]; op_w = mem[5]; end
            default: begin op_x = '0;     op_w = '0;     end
        endcase
    end

endmodule

// File: rtl/neuron_operand_loader.sv
// neuron_operand_loader: collects six operand words (x1,w1,x2,w2,x3,w3) from
// a valid/ready stream into an operand bank, signals ready to neuron_control
// and drives the selected x/w pair onto the multiplier operand bus.
// Optional feature macro: OPLOAD_DOUBLE_BUF_EN adds a shadow bank that fills
// while the neuron computes and is swapped in on buf_rst.
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// in_ready never depends on in_valid, and upstream holds in_data until taken.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_data      : upstream word stream
//   in_ready              : loader can accept a word this cycle
//   sel                   : pair select from neuron_control
//   buf_rst               : synchronous bank clear, highest priority
//   neuron_done           : completion pulse from neuron_control
//   ready                 : bank full, neuron may start (registered)
//   op_x/op_w             : selected operands
//   busy                  : high in FULL, RUN and DRAIN (registered)
//   state_dbg, cnt_dbg    : FSM state and active fill count for observation
module neuron_operand_loader
    import dnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [1:0]        sel,
    input  logic              buf_rst,
    input  logic              neuron_done,
    output logic              ready,
    output logic [DATA_W-1:0] op_x,
    output logic [DATA_W-1:0] op_w,
    output logic              busy,
    output load_state_t       state_dbg,
    output logic [CNT_W-1:0]  cnt_dbg
);

    load_state_t      state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             act_we;

    assign accept    = in_valid && in_ready;
    assign act_we    = accept && (state == LOAD);
    assign state_dbg = state;
    assign cnt_dbg   = cnt;

`ifdef OPLOAD_DOUBLE_BUF_EN
    logic [CNT_W-1:0]          shadow_cnt;
    logic                      shadow_we;
    logic [N_WORDS*DATA_W-1:0] shadow_words;
    logic [N_WORDS*DATA_W-1:0] active_words;
    logic [DATA_W-1:0]         shadow_x, shadow_w;

    assign shadow_we = accept && (state != LOAD);

    // Gated by reset so in_ready stays low while reset is held.
    always_comb begin
        in_ready = 1'b0;
        if (!reset && !buf_rst) begin
            if (state == LOAD) in_ready = 1'b1;
            else               in_ready = (shadow_cnt < CNT_W'(N_WORDS));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          shadow_cnt <= '0;
        else if (buf_rst)   shadow_cnt <= '0;
        else if (shadow_we) shadow_cnt <= shadow_cnt + 1'b1;
    end

    // Active bank takes the shadow contents on buf_rst instead of clearing.
    operand_bank #(.DATA_W(DATA_W)) u_active (
        .clk(clk), .reset(reset), .clr(1'b0),
        .we(act_we), .waddr(cnt), .wdata(in_data), .sel(sel),
        .copy_en(buf_rst), .copy_data(shadow_words), .words(active_words),
        .op_x(op_x), .op_w(op_w)
    );

    operand_bank #(.DATA_W(DATA_W)) u_shadow (
        .clk(clk), .reset(reset), .clr(buf_rst),
        .we(shadow_we), .waddr(shadow_cnt), .wdata(in_data), .sel(SEL_NONE),
        .copy_en(1'b0), .copy_data(active_words), .words(shadow_words),
        .op_x(shadow_x), .op_w(shadow_w)
    );
`else
    assign in_ready = !reset && !buf_rst && (state == LOAD);

    operand_bank #(.DATA_W(DATA_W)) u_active (
        .clk(clk), .reset(reset), .clr(buf_rst),
        .we(act_we), .waddr(cnt), .wdata(in_data), .sel(sel),
        .op_x(op_x), .op_w(op_w)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (buf_rst) begin
`ifdef OPLOAD_DOUBLE_BUF_EN
            cnt <= shadow_cnt;
`else
            cnt <= '0;
`endif
        end else if (act_we) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
            ready <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == FULL);
            busy  <= (state_next != LOAD);
        end
    end

    always_comb begin
        state_next = state;
        if (buf_rst) begin
`ifdef OPLOAD_DOUBLE_BUF_EN
            state_next = (shadow_cnt == CNT_W'(N_WORDS)) ? FULL : LOAD;
`else
            state_next = LOAD;
`endif
        end else begin
            case (state)
                LOAD:  if (act_we && (cnt == CNT_W'(N_WORDS - 1))) state_next = FULL;
                FULL:  if (sel != SEL_NONE) state_next = RUN;
                RUN:   if (neuron_done) state_next = DRAIN;
                DRAIN: state_next = DRAIN;
                default: state_next = LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_operand_loader.sv
module tb_neuron_operand_loader;
  import dnn_pkg::*;

  localparam int W  = 32;
  localparam int VW = 1 + 1 + 1 + 2 + 3 + W + W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_ready;
  logic [1:0]       sel = 2'd0;
  logic             buf_rst = 1'b0;
  logic             neuron_done = 1'b0;
  logic             ready;
  logic [W-1:0]     op_x, op_w;
  logic             busy;
  load_state_t      state_dbg;
  logic [CNT_W-1:0] cnt_dbg;

  logic [VW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  neuron_operand_loader #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sel(sel), .buf_rst(buf_rst), .neuron_done(neuron_done),
    .ready(ready), .op_x(op_x), .op_w(op_w), .busy(busy),
    .state_dbg(state_dbg), .cnt_dbg(cnt_dbg)
  );

  // Drive one cycle of inputs just after the rising edge and queue the outputs
  // expected for that cycle (state values are what the previous edge produced).
  task automatic cyc(input logic rst, input logic v, input logic [W-1:0] d,
                     input logic [1:0] s, input logic br, input logic dn,
                     input logic e_ir, input logic e_rdy, input logic e_busy,
                     input logic [1:0] e_st, input logic [2:0] e_cnt,
                     input logic [W-1:0] e_x, input logic [W-1:0] e_w,
                     input string tag);
    @(posedge clk);
    #1;
    reset = rst; in_valid = v; in_data = d; sel = s; buf_rst = br; neuron_done = dn;
    exp_q.push_back({e_ir, e_rdy, e_busy, e_st, e_cnt, e_x, e_w});
    tag_q.push_back(tag);
  endtask

  // Monitor: compares the DUT outputs at the falling edge against the queue.
  always @(negedge clk) begin
    logic [VW-1:0] e, g;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = {in_ready, ready, busy, 2'(state_dbg), cnt_dbg, op_x, op_w};
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got ir=%b rdy=%b busy=%b st=%0d cnt=%0d x=%0d w=%0d, need ir=%b rdy=%b busy=%b st=%0d cnt=%0d x=%0d w=%0d",
                 t, g[VW-1], g[VW-2], g[VW-3], g[VW-4:VW-5], g[VW-6:VW-8], g[2*W-1:W], g[W-1:0],
                 e[VW-1], e[VW-2], e[VW-3], e[VW-4:VW-5], e[VW-6:VW-8], e[2*W-1:W], e[W-1:0]);
      end
    end
  end

  initial begin
    //  rst v  d   s  br dn | ir rdy bsy st cnt x  w
    cyc(1, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0, "reset_held");
    cyc(0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0, "reset_release");
    // Back-to-back load 1..6
    for (int k = 1; k <= 6; k++)
      cyc(0, 1, k,  0, 0, 0, 1, 0, 0, 0, 3'(k-1), 0, 0, "load_word");
    cyc(0, 1, 99, 0, 0, 0,   0, 1, 1, 1, 6, 0, 0, "full_ready");
    // Mux check
    cyc(0, 0, 0,  1, 0, 0,   0, 1, 1, 1, 6, 1, 2, "mux_p1_full");
    cyc(0, 0, 0,  2, 0, 0,   0, 0, 1, 2, 6, 3, 4, "mux_p2_run");
    cyc(0, 0, 0,  3, 0, 0,   0, 0, 1, 2, 6, 5, 6, "mux_p3");
    cyc(0, 0, 0,  0, 0, 0,   0, 0, 1, 2, 6, 0, 0, "mux_none");
    // Completion: done, then buf_rst
    cyc(0, 0, 0,  1, 0, 1,   0, 0, 1, 2, 6, 1, 2, "done_pulse");
    cyc(0, 0, 0,  1, 1, 0,   0, 0, 1, 3, 6, 1, 2, "drain_bufrst");
    cyc(0, 0, 0,  1, 0, 0,   1, 0, 0, 0, 0, 0, 0, "cleared_load");
    // Conflict on 3rd word
    cyc(0, 1, 10, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, "conf_w1");
    cyc(0, 1, 11, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0, "conf_w2");
    cyc(0, 1, 12, 0, 1, 0,   0, 0, 0, 0, 2, 0, 0, "conf_w3_bufrst");
    cyc(0, 1, 12, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0, "conf_cleared_sel_in_load");
    cyc(0, 1, 13, 1, 0, 0,   1, 0, 0, 0, 1, 12, 0, "sel_ignored_in_load");
    for (int k = 14; k <= 17; k++)
      cyc(0, 1, k,  0, 0, 0, 1, 0, 0, 0, 3'(k-12), 0, 0, "reload_word");
    cyc(0, 0, 0,  0, 0, 0,   0, 1, 1, 1, 6, 0, 0, "reload_full");
    cyc(0, 0, 0,  2, 0, 0,   0, 1, 1, 1, 6, 14, 15, "reload_p2");
    cyc(0, 0, 0,  3, 0, 0,   0, 0, 1, 2, 6, 16, 17, "reload_run_p3");
    // Abort with async reset in RUN
    cyc(1, 0, 0,  3, 0, 0,   0, 0, 0, 0, 0, 0, 0, "abort_reset");
    cyc(0, 0, 0,  3, 0, 0,   1, 0, 0, 0, 0, 0, 0, "abort_release");
    // neuron_done coinciding with buf_rst: clear wins
    for (int k = 1; k <= 6; k++)
      cyc(0, 1, 20+k, 0, 0, 0, 1, 0, 0, 0, 3'(k-1), 0, 0, "load3_word");
    cyc(0, 0, 0,  1, 0, 0,   0, 1, 1, 1, 6, 21, 22, "load3_p1");
    cyc(0, 0, 0,  1, 1, 1,   0, 0, 1, 2, 6, 21, 22, "done_with_bufrst");
    cyc(0, 0, 0,  1, 0, 0,   1, 0, 0, 0, 0, 0, 0, "done_bufrst_load");

    @(posedge clk);
    #1;
    in_valid = 0; sel = 0; buf_rst = 0; neuron_done = 0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d expectations left, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
